gray_counter: RTL and testbench

Parametrised up/down Gray-code counter, the successor to the fixed 3-bit incrementing Gray counter. Adds configurable width, decrement, synchronous load, a wrap or saturate limit mode, a registered binary view and a wrap/limit event pulse. The Gray output comes straight from flops, so it is safe to send across a clock-domain boundary, for example as a FIFO pointer.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_to_bin_converter.sv | 21 ++
 rtl/gray_counter.sv | 96 +++++++++
 tb/tb_gray_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers for the gray counter family
// Contents:
//   GRAY_MAX_W      widest vector the helpers accept
//   bin2gray(b)     b ^ (b >> 1), zero-extend narrower operands into 64 bits
//   gray2bin(g)     prefix-XOR inverse of bin2gray, for benches
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  // Zero upper bits stay zero through the shift/XOR, so callers can
  // zero-extend a narrow operand and truncate the result back.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_converter.sv
// rtl/gray_to_bin_converter.sv - combinational Gray to binary decoder
// Ports:
//   gray_i  in   LENGTH  Gray-coded value
//   bin_o   out  LENGTH  binary equivalent
module gray_to_bin_converter #(
  parameter int LENGTH = 4
) (
  input  logic [LENGTH-1:0] gray_i,
  output logic [LENGTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    bin_o[LENGTH-1] = gray_i[LENGTH-1];
    for (int i = LENGTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - parametrised up/down Gray counter with load and wrap/saturate limit
// Parameters:
//   WIDTH        counter width, 2..64
//   SATURATE     0 = wrap modulo 2^WIDTH, 1 = hold at the limits
//   RESET_VALUE  binary value forced while reset_i is high
// Ports:
//   clk_i         in   1      rising-edge clock
//   reset_i       in   1      asynchronous active-high reset
//   incr_i        in   1      +1 request
//   decr_i        in   1      -1 request
//   load_i        in   1      synchronous load, highest priority
//   load_value_i  in   WIDTH  binary value to load
//   count_o       out  WIDTH  Gray count, straight from a flop (CDC-safe)
//   count_bin_o   out  WIDTH  binary count, same alignment as count_o
//   limit_o       out  1      registered wrap / blocked-step pulse
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             incr_i,
  input  logic             decr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_bin_o,
  output logic             limit_o
);

  if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("gray_counter: WIDTH must be in 2..64");
  end

  if (RESET_VALUE < 0 || (WIDTH < 32 && RESET_VALUE >= (1 << WIDTH))) begin : g_bad_reset
    $error("gray_counter: RESET_VALUE must be in 0..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RESET_BIN)));

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             limit_q, limit_d;

  logic at_max, at_min, step_up, step_dn;

  always_comb begin
    bin_d   = bin_q;
    limit_d = 1'b0;
    at_max  = &bin_q;
    at_min  = ~|bin_q;
    // Simultaneous incr/decr cancels out and is treated as idle.
    step_up = incr_i && !decr_i;
    step_dn = decr_i && !incr_i;

    if (load_i) begin
      bin_d = load_value_i;
    end else if (step_up) begin
      limit_d = at_max;
      // WIDTH-bit add wraps all-ones to zero on its own.
      if (!(SATURATE && at_max)) begin
        bin_d = bin_q + WIDTH'(1);
      end
    end else if (step_dn) begin
      limit_d = at_min;
      if (!(SATURATE && at_min)) begin
        bin_d = bin_q - WIDTH'(1);
      end
    end

    // Gray is re-derived from the next binary value and registered, so
    // count_o never passes through combinational logic after the flop.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bin_q   <= RESET_BIN;
      gray_q  <= RESET_GRAY;
      limit_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      limit_q <= limit_d;
    end
  end

  assign count_o     = gray_q;
  assign count_bin_o = bin_q;
  assign limit_o     = limit_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter (wrap, saturate, reset value)
module tb_gray_counter;

  localparam int N = 3;
  localparam int W = 3;
  localparam int MODV = 1 << W;

  // Instance 0: wrap, reset 0; 1: saturate, reset 0; 2: wrap, reset 3.
  localparam bit SAT_TAB [N] = '{1'b0, 1'b1, 1'b0};
  localparam int RV_TAB  [N] = '{0, 0, 3};

  logic         clk = 1'b0;
  logic         rst;
  logic         incr, decr, load;
  logic [W-1:0] lv;

  logic [W-1:0] cnt  [N];
  logic [W-1:0] cbin [N];
  logic [W-1:0] conv [N];
  logic         lim  [N];

  int mb [N];
  bit ml [N];
  logic [W-1:0] prev [N];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .SATURATE(1'b0), .RESET_VALUE(0)) u_wrap (
    .clk_i(clk), .reset_i(rst), .incr_i(incr), .decr_i(decr), .load_i(load),
    .load_value_i(lv), .count_o(cnt[0]), .count_bin_o(cbin[0]), .limit_o(lim[0]));

  gray_counter #(.WIDTH(W), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk_i(clk), .reset_i(rst), .incr_i(incr), .decr_i(decr), .load_i(load),
    .load_value_i(lv), .count_o(cnt[1]), .count_bin_o(cbin[1]), .limit_o(lim[1]));

  gray_counter #(.WIDTH(W), .SATURATE(1'b0), .RESET_VALUE(3)) u_rv3 (
    .clk_i(clk), .reset_i(rst), .incr_i(incr), .decr_i(decr), .load_i(load),
    .load_value_i(lv), .count_o(cnt[2]), .count_bin_o(cbin[2]), .limit_o(lim[2]));

  gray_to_bin_converter #(.LENGTH(W)) u_conv0 (.gray_i(cnt[0]), .bin_o(conv[0]));
  gray_to_bin_converter #(.LENGTH(W)) u_conv1 (.gray_i(cnt[1]), .bin_o(conv[1]));
  gray_to_bin_converter #(.LENGTH(W)) u_conv2 (.gray_i(cnt[2]), .bin_o(conv[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: integer counter, range [0, 2^W), out-of-range step
  // either wraps modulo 2^W or is refused, and raises the limit flag.
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mb[k] = RV_TAB[k];
      ml[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int nb;
    for (int k = 0; k < N; k++) begin
      ml[k] = 1'b0;
      if (rst) begin
        mb[k] = RV_TAB[k];
      end else if (load) begin
        mb[k] = int'(lv);
      end else if (incr != decr) begin
        nb = mb[k] + (incr ? 1 : -1);
        if (nb < 0 || nb >= MODV) begin
          ml[k] = 1'b1;
          if (!SAT_TAB[k]) mb[k] = (nb + MODV) % MODV;
        end else begin
          mb[k] = nb;
        end
      end
    end
  endtask

  task automatic check_all(input bit was_load);
    int eg;
    for (int k = 0; k < N; k++) begin
      eg = mb[k] ^ (mb[k] >> 1);
      check($sformatf("bin%0d", k), 32'(cbin[k]), 32'(mb[k]));
      check($sformatf("gray%0d", k), 32'(cnt[k]), 32'(eg));
      check($sformatf("limit%0d", k), 32'(lim[k]), 32'(ml[k]));
      check($sformatf("conv%0d", k), 32'(conv[k]), 32'(cbin[k]));
      if (!was_load)
        check($sformatf("onebit%0d", k), 32'($countones(cnt[k] ^ prev[k]) <= 1), 32'd1);
      prev[k] = cnt[k];
    end
  endtask

  // Called at a falling edge; applies inputs, clocks once, checks at next falling edge.
  task automatic cycle(input bit i, input bit d, input bit l, input logic [W-1:0] v);
    incr = i; decr = d; load = l; lv = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(l);
  endtask

  initial begin
    rst = 1'b1; incr = 1'b0; decr = 1'b0; load = 1'b0; lv = '0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) prev[k] = cnt[k];
    check_all(1'b1);
    check("rst_gray_rv3", 32'(cnt[2]), 32'h2);
    rst = 1'b0;

    // Continuous increment: wrap after 7 on instance 0, saturate on 1.
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      if (c == 7) check("wrap_pulse", 32'(lim[0]), 32'd1);
    end

    // Decrement from 0 wraps to 7 with a pulse.
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("decwrap_bin", 32'(cbin[0]), 32'd7);
    check("decwrap_gray", 32'(cnt[0]), 32'h4);

    // Saturating up from 6, then down from 1.
    cycle(1'b0, 1'b0, 1'b1, 3'd6);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);
    check("sat_hi", 32'({cbin[1], lim[1]}), 32'({3'd7, 1'b1}));
    cycle(1'b0, 1'b0, 1'b1, 3'd1);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, '0);
    check("sat_lo", 32'({cbin[1], lim[1]}), 32'({3'd0, 1'b1}));

    // Priority: load beats incr; incr+decr holds.
    cycle(1'b1, 1'b0, 1'b1, 3'd5);
    check("load5_gray", 32'(cnt[0]), 32'h7);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("both_hold", 32'(cbin[0]), 32'd5);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)));
    end

    // Asynchronous reset between edges, held over an edge with incr high.
    cycle(1'b1, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_bin", 32'(cbin[2]), 32'd3);
    check("async_rst_gray", 32'(cnt[2]), 32'h2);
    check("async_rst_lim", 32'(lim[2]), 32'd0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(1'b1);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("post_rst_bin", 32'(cbin[2]), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
